accel_sample_collector: RTL and testbench



---
 rtl/accel_pkg.sv | 41 ++++
 rtl/poll_timer.sv | 41 ++++
 rtl/accel_sample_collector.sv | 157 +++++++++++++++
 tb/tb_accel_sample_collector.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : accel_pkg
//  Purpose  : Shared types and constants for the accelerometer sample
//             collector: FSM encoding, burst length, byte-order indices,
//             default I2C addressing and a saturating counter helper.
//  Revision : 1.0  initial release
// ============================================================================
package accel_pkg;

    // Collector FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_RECV   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Number of bytes in one X/Y/Z burst
    localparam int BURST_LEN = 6;

    // Position of each axis byte inside the burst (little-endian per axis)
    localparam int IDX_X0 = 0;
    localparam int IDX_X1 = 1;
    localparam int IDX_Y0 = 2;
    localparam int IDX_Y1 = 3;
    localparam int IDX_Z0 = 4;
    localparam int IDX_Z1 = 5;

    // Default slave address and first data register of the burst
    localparam logic [6:0] DEF_DEV_ADDR  = 7'h53;
    localparam logic [7:0] DEF_START_REG = 8'h32;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poll_timer.sv
`default_nettype none
// ============================================================================
//  Module   : poll_timer
//  Purpose  : Free-running 0..DIV-1 counter with hold (enable), synchronous
//             clear and a single-cycle wrap indication.
//  Revision : 1.0  initial release
// ============================================================================
module poll_timer #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic arstn,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Counter: clear wins, otherwise advance while enabled and wrap at LAST
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign wrap = enable && !clear && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/accel_sample_collector.sv
`default_nettype none
// ============================================================================
//  Module   : accel_sample_collector
//  Purpose  : Periodically requests a six-byte burst from the accelerometer
//             through the I2C master, assembles X/Y/Z words and publishes
//             them only when the whole burst arrived without error.
//  Revision : 1.0  initial release
// ============================================================================
module accel_sample_collector
    import accel_pkg::*;
#(
    parameter int         POLL_DIV  = 1000000,
    parameter logic [6:0] DEV_ADDR  = DEF_DEV_ADDR,
    parameter logic [7:0] START_REG = DEF_START_REG,
    parameter int         TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        enable,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [6:0]  req_dev,
    output logic [7:0]  req_reg,
    output logic [2:0]  req_len,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_nack,
    input  logic        rx_done,
    output logic [15:0] data_x,
    output logic [15:0] data_y,
    output logic [15:0] data_z,
    output logic        sample_stb,
    output logic [7:0]  err_cnt
);

    localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]    LEN_CNT = 3'(BURST_LEN);

    state_t                      state;
    logic                        poll_pending;
    logic                        poll_wrap;
    logic [2:0]                  byte_cnt;
    logic [TW-1:0]               to_cnt;
    logic [BURST_LEN-1:0][7:0]   shadow;

    logic                        byte_take;
    logic [2:0]                  cnt_nxt;
    logic [BURST_LEN-1:0][7:0]   shadow_nxt;

    assign req_dev = DEV_ADDR;
    assign req_reg = START_REG;
    assign req_len = LEN_CNT;

    poll_timer #(
        .DIV (POLL_DIV)
    ) u_poll_timer (
        .clk    (clk),
        .arstn  (arstn),
        .enable (enable),
        .clear  (!enable),
        .wrap   (poll_wrap)
    );

    // Single pending-poll flag; a wrap while already pending is dropped
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            poll_pending <= 1'b0;
        end else if (!enable) begin
            poll_pending <= 1'b0;
        end else if (state == ST_IDLE && poll_pending) begin
            poll_pending <= 1'b0;
        end else if (poll_wrap) begin
            poll_pending <= 1'b1;
        end
    end

    // Shadow/byte count as they will be after this cycle, so a byte that
    // arrives together with rx_done still counts and still gets committed
    always_comb begin
        byte_take  = (state == ST_RECV) && rx_valid && (byte_cnt != LEN_CNT);
        shadow_nxt = shadow;
        cnt_nxt    = byte_cnt;
        if (byte_take) begin
            shadow_nxt[byte_cnt] = rx_data;
            cnt_nxt              = byte_cnt + 3'd1;
        end
    end

    // Collector FSM with registered request, sample and error outputs
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= ST_IDLE;
            req_valid  <= 1'b0;
            byte_cnt   <= '0;
            to_cnt     <= '0;
            shadow     <= '0;
            data_x     <= '0;
            data_y     <= '0;
            data_z     <= '0;
            sample_stb <= 1'b0;
            err_cnt    <= '0;
        end else begin
            sample_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (poll_pending) begin
                        state     <= ST_REQ;
                        req_valid <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (req_valid && req_ready) begin
                        state     <= ST_RECV;
                        req_valid <= 1'b0;
                        byte_cnt  <= '0;
                        to_cnt    <= '0;
                    end
                end
                ST_RECV: begin
                    shadow   <= shadow_nxt;
                    byte_cnt <= cnt_nxt;
                    to_cnt   <= to_cnt + TW'(1);
                    if (rx_nack) begin
                        state   <= ST_ERR;
                        err_cnt <= sat_inc8(err_cnt);
                    end else if (rx_done) begin
                        if (cnt_nxt == LEN_CNT) begin
                            state      <= ST_COMMIT;
                            data_x     <= {shadow_nxt[IDX_X1], shadow_nxt[IDX_X0]};
                            data_y     <= {shadow_nxt[IDX_Y1], shadow_nxt[IDX_Y0]};
                            data_z     <= {shadow_nxt[IDX_Z1], shadow_nxt[IDX_Z0]};
                            sample_stb <= 1'b1;
                        end else begin
                            state   <= ST_ERR;
                            err_cnt <= sat_inc8(err_cnt);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state   <= ST_ERR;
                        err_cnt <= sat_inc8(err_cnt);
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accel_sample_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accel_sample_collector
//  Purpose  : Self-checking bench for accel_sample_collector, acting as the
//             I2C master and comparing against a burst-level outcome model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_accel_sample_collector;

    localparam int TB_POLL_DIV = 16;
    localparam int TB_TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        arstn;
    logic        enable;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_dev;
    logic [7:0]  req_reg;
    logic [2:0]  req_len;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_nack;
    logic        rx_done;
    logic [15:0] data_x;
    logic [15:0] data_y;
    logic [15:0] data_z;
    logic        sample_stb;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    accel_sample_collector #(
        .POLL_DIV  (TB_POLL_DIV),
        .DEV_ADDR  (7'h53),
        .START_REG (8'h32),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .arstn      (arstn),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dev    (req_dev),
        .req_reg    (req_reg),
        .req_len    (req_len),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_nack    (rx_nack),
        .rx_done    (rx_done),
        .data_x     (data_x),
        .data_y     (data_y),
        .data_z     (data_z),
        .sample_stb (sample_stb),
        .err_cnt    (err_cnt)
    );

    int checks = 0;
    int errors = 0;
    int stb_seen = 0;

    // Reference model state: last published sample, error count, commits
    logic [15:0] mx, my, mz;
    logic [7:0]  merr;
    int          mstb;

    // Burst modes: 0 = finish with rx_done, 1 = rx_nack, 2 = never finish
    typedef struct {
        int          n;
        int          mode;
        bit          coincide;
        bit          nack_done;
        int          rdelay;
        logic [63:0] b;
        logic [15:0] ex;
        logic [15:0] ey;
        logic [15:0] ez;
        logic [7:0]  eerr;
        int          estb;
    } vec_t;

    vec_t tbl[7];

    always @(negedge clk) if (sample_stb) stb_seen++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = '0; my = '0; mz = '0; merr = '0; mstb = 0;
    endtask

    // Outcome of one burst from the rules: six good bytes + done commits the
    // first six, everything else is one (saturating) error
    task automatic model_burst(input int n, input int mode, input logic [63:0] b);
        int eff;
        eff = (n > 6) ? 6 : n;
        if (mode == 0 && eff == 6) begin
            mx = b[15:0]; my = b[31:16]; mz = b[47:32];
            mstb++;
        end else if (merr != 8'hFF) begin
            merr = merr + 8'd1;
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, "_x"},   {16'h0, data_x}, {16'h0, mx});
        chk({tag, "_y"},   {16'h0, data_y}, {16'h0, my});
        chk({tag, "_z"},   {16'h0, data_z}, {16'h0, mz});
        chk({tag, "_err"}, {24'h0, err_cnt}, {24'h0, merr});
        chk({tag, "_stb"}, stb_seen, mstb);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_req: got req_valid=0 for 200 cycles expected 1");
        end
    endtask

    task automatic accept();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    task automatic send_bytes(input int n, input bit done_last, input bit gaps, input logic [63:0] b);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = b[8*i +: 8];
            if (done_last && i == n - 1) rx_done = 1'b1;
            tick();
            rx_valid = 1'b0;
            rx_done  = 1'b0;
            if (gaps && $urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic run_burst(input int n, input int mode, input bit coincide, input bit nack_done,
                             input int rdelay, input bit gaps, input logic [63:0] b);
        bit ok;
        int hi;
        bit done_last;
        wait_req(ok);
        if (!ok) return;
        if (rdelay > 0) begin
            hi = 0;
            for (int d = 0; d < rdelay; d++) begin
                if (req_valid) hi++;
                tick();
            end
            chk("req_held", hi, rdelay);
        end
        accept();
        done_last = (mode == 0) && coincide && (n > 0);
        send_bytes(n, done_last, gaps, b);
        case (mode)
            0: if (!done_last) begin
                rx_done = 1'b1; tick(); rx_done = 1'b0;
            end
            1: begin
                rx_nack = 1'b1; rx_done = nack_done; tick();
                rx_nack = 1'b0; rx_done = 1'b0;
            end
            default: repeat (TB_TIMEOUT + 2) tick();
        endcase
        tick();
        tick();
        model_burst(n, mode, b);
    endtask

    initial begin
        bit ok;
        int cnt;
        logic [63:0] rb;
        int n, mode, pick;

        arstn = 1'b0; enable = 1'b1; req_ready = 1'b0;
        rx_data = '0; rx_valid = 1'b0; rx_nack = 1'b0; rx_done = 1'b0;
        model_reset();

        tbl[0] = '{6, 0, 0, 0, 0,  64'h0000_9ABC_5678_1234, 16'h1234, 16'h5678, 16'h9ABC, 8'd0, 1};
        tbl[1] = '{3, 1, 0, 0, 0,  64'h0000_0000_0033_2211, 16'h1234, 16'h5678, 16'h9ABC, 8'd1, 1};
        tbl[2] = '{6, 0, 1, 0, 0,  64'h0000_0605_0403_0201, 16'h0201, 16'h0403, 16'h0605, 8'd1, 2};
        tbl[3] = '{5, 0, 0, 0, 0,  64'h0000_00EE_DDCC_BBAA, 16'h0201, 16'h0403, 16'h0605, 8'd2, 2};
        tbl[4] = '{7, 0, 0, 0, 0,  64'h0070_6050_4030_2010, 16'h2010, 16'h4030, 16'h6050, 8'd2, 3};
        tbl[5] = '{6, 1, 0, 1, 0,  64'h0000_FFFF_FFFF_FFFF, 16'h2010, 16'h4030, 16'h6050, 8'd3, 3};
        tbl[6] = '{6, 0, 0, 0, 40, 64'h0000_F00D_DEAD_BEEF, 16'hBEEF, 16'hDEAD, 16'hF00D, 8'd3, 4};

        // Reset state
        repeat (3) tick();
        chk("rst_x", {16'h0, data_x}, 32'h0);
        chk("rst_y", {16'h0, data_y}, 32'h0);
        chk("rst_z", {16'h0, data_z}, 32'h0);
        chk("rst_err", {24'h0, err_cnt}, 32'h0);
        chk("rst_stb", {31'h0, sample_stb}, 32'h0);
        chk("rst_req", {31'h0, req_valid}, 32'h0);
        chk("req_dev", {25'h0, req_dev}, 32'h53);
        chk("req_reg", {24'h0, req_reg}, 32'h32);
        chk("req_len", {29'h0, req_len}, 32'h6);

        // First request: POLL_DIV counts to the wrap, then two more cycles
        @(posedge clk); #1; arstn = 1'b1;
        repeat (TB_POLL_DIV) tick();
        chk("lat_early", {31'h0, req_valid}, 32'h0);
        tick();
        chk("lat_req", {31'h0, req_valid}, 32'h1);

        // Table-driven bursts
        for (int t = 0; t < 7; t++) begin
            run_burst(tbl[t].n, tbl[t].mode, tbl[t].coincide, tbl[t].nack_done, tbl[t].rdelay, 1'b0, tbl[t].b);
            chk($sformatf("t%0d_x", t), {16'h0, data_x}, {16'h0, tbl[t].ex});
            chk($sformatf("t%0d_y", t), {16'h0, data_y}, {16'h0, tbl[t].ey});
            chk($sformatf("t%0d_z", t), {16'h0, data_z}, {16'h0, tbl[t].ez});
            chk($sformatf("t%0d_err", t), {24'h0, err_cnt}, {24'h0, tbl[t].eerr});
            chk($sformatf("t%0d_stb", t), stb_seen, tbl[t].estb);
        end

        // Randomized bursts against the model
        for (int r = 0; r < 24; r++) begin
            pick = $urandom_range(0, 9);
            mode = (pick <= 5) ? 0 : ((pick <= 8) ? 1 : 2);
            n = $urandom_range(0, 8);
            if (mode == 0 && $urandom_range(0, 1) == 1) n = 6;
            rb = {$urandom, $urandom};
            run_burst(n, mode, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), 1'b1, rb);
            compare_model($sformatf("r%0d", r));
        end

        // Timeout fires exactly in the TIMEOUT-th cycle of reception
        wait_req(ok);
        accept();
        repeat (TB_TIMEOUT - 1) tick();
        chk("to_before", {24'h0, err_cnt}, {24'h0, merr});
        tick();
        if (merr != 8'hFF) merr = merr + 8'd1;
        chk("to_at", {24'h0, err_cnt}, {24'h0, merr});
        tick(); tick();

        // Receive strobes outside reception are ignored
        rx_valid = 1'b1; rx_data = 8'h77; rx_done = 1'b1;
        tick();
        rx_valid = 1'b0; rx_done = 1'b0;
        repeat (3) tick();
        compare_model("stray");

        // Disable during a burst: the burst still commits, then no requests
        wait_req(ok);
        accept();
        enable = 1'b0;
        send_bytes(6, 1'b0, 1'b0, 64'h0000_3333_2222_1111);
        rx_done = 1'b1; tick(); rx_done = 1'b0;
        tick(); tick();
        model_burst(6, 0, 64'h0000_3333_2222_1111);
        compare_model("dis");
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (req_valid) cnt++;
            tick();
        end
        chk("dis_noreq", cnt, 0);
        enable = 1'b1;

        // Error counter saturation
        for (int k = 0; k < 260; k++) begin
            run_burst(0, 1, 1'b0, 1'b0, 0, 1'b0, 64'h0);
        end
        compare_model("sat");
        chk("sat_ff", {24'h0, err_cnt}, 32'hFF);

        // Asynchronous reset in the middle of reception
        wait_req(ok);
        accept();
        send_bytes(4, 1'b0, 1'b0, 64'h0000_0000_4444_4444);
        #2 arstn = 1'b0;
        #1;
        chk("arst_x", {16'h0, data_x}, 32'h0);
        chk("arst_y", {16'h0, data_y}, 32'h0);
        chk("arst_z", {16'h0, data_z}, 32'h0);
        chk("arst_err", {24'h0, err_cnt}, 32'h0);
        chk("arst_req", {31'h0, req_valid}, 32'h0);
        model_reset();
        stb_seen = 0;
        @(posedge clk); #1; arstn = 1'b1;

        // Collector recovers and completes a clean burst after reset
        run_burst(6, 0, 1'b0, 1'b0, 0, 1'b0, 64'h0000_0C0B_0A09_0807);
        compare_model("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
